// File: rtl/hazard_pkg.sv
// Shared encodings and shadow-pipeline entry for the hazard/forwarding unit.
// Register addresses are carried at RW_MAX bits so the entry type is fixed.
package hazard_pkg;

  localparam int RW_MAX = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef logic [RW_MAX-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t dest;
    logic wb;
    logic is_load;
  } shadow_t;

  localparam shadow_t SHADOW_NOP = '0;

  function automatic logic src_match(
    input shadow_t s,
    input reg_t    src,
    input logic    used,
    input logic    zero_reg
  );
    return s.valid & s.wb & used
         & (src == s.dest)
         & !(zero_reg & (src == '0));
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// One source operand: compare against EX/MEM/WB writers,
// pick the youngest match and flag a match on an EX load.
module fwd_operand_sel
  import hazard_pkg::*;
#(
  parameter bit ZERO_REG = 1'b0
) (
  input  reg_t       src_i,
  input  logic       used_i,
  input  shadow_t    ex_i,
  input  shadow_t    mem_i,
  input  shadow_t    wb_i,
  output logic [1:0] sel_o,
  output logic       load_hit_o
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign hit_ex  = src_match(ex_i, src_i, used_i, ZERO_REG);
  assign hit_mem = src_match(mem_i, src_i, used_i, ZERO_REG);
  assign hit_wb  = src_match(wb_i, src_i, used_i, ZERO_REG);

  // several stages may hold the same dest; the youngest wins
  always_comb begin
    sel_o = FWD_RF;
    priority case (1'b1)
      hit_ex:  sel_o = FWD_EX;
      hit_mem: sel_o = FWD_MEM;
      hit_wb:  sel_o = FWD_WB;
      default: sel_o = FWD_RF;
    endcase
  end

  assign load_hit_o = hit_ex & ex_i.is_load;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline:
// shadow writer pipeline, load-use stall counter, stall statistics.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int RW         = 3,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [NUM_SRC*RW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic [RW-1:0]         id_dest,
  input  logic                  id_wb,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [2*NUM_SRC-1:0]  fwd_sel,
  output logic                  stall,
  output logic                  ex_bubble,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [2:0] RELOAD = 3'(LOAD_STALL - 1);

  shadow_t ex_q;
  shadow_t ex_d;
  shadow_t mem_q;
  shadow_t wb_q;

  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;
  logic [CNT_W-1:0] stat_q;
  logic [CNT_W-1:0] stat_d;

  logic [NUM_SRC-1:0] load_hit;
  logic               hazard;
  logic               stalling;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    reg_t src;
    assign src = reg_t'(id_src[i*RW +: RW]);

    fwd_operand_sel #(
      .ZERO_REG (ZERO_REG != 0)
    ) u_sel (
      .src_i      (src),
      .used_i     (id_src_used[i]),
      .ex_i       (ex_q),
      .mem_i      (mem_q),
      .wb_i       (wb_q),
      .sel_o      (fwd_sel[2*i +: 2]),
      .load_hit_o (load_hit[i])
    );
  end

  assign stalling  = (cnt_q != 3'd0);
  assign hazard    = id_valid & (|load_hit);
  assign stall     = !flush & (hazard | stalling);
  assign ex_bubble = flush | stall | !id_valid;

  always_comb begin
    ex_d = SHADOW_NOP;
    if (!ex_bubble) begin
      ex_d.valid   = 1'b1;
      ex_d.dest    = reg_t'(id_dest);
      ex_d.wb      = id_wb;
      ex_d.is_load = id_is_load;
    end
  end

  // while counting, EX holds a bubble so a new hazard cannot appear
  always_comb begin
    cnt_d = 3'd0;
    if (flush)
      cnt_d = 3'd0;
    else if (stalling)
      cnt_d = cnt_q - 3'd1;
    else if (hazard)
      cnt_d = RELOAD;
  end

  always_comb begin
    stat_d = stat_q;
    if (stall && !(&stat_q))
      stat_d = stat_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q   <= SHADOW_NOP;
      mem_q  <= SHADOW_NOP;
      wb_q   <= SHADOW_NOP;
      cnt_q  <= 3'd0;
      stat_q <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_q   <= mem_q;
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
    end
  end

  assign stall_count = stat_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: three configurations share the ID stimulus
// (LOAD_STALL=1, LOAD_STALL=3 with CNT_W=2, ZERO_REG=1).
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_src;
  logic [1:0] id_src_used;
  logic [2:0] id_dest;
  logic       id_wb;
  logic       id_is_load;
  logic       flush;

  logic [3:0]  fs1, fs3, fsz;
  logic        st1, st3, stz;
  logic        eb1, eb3, ebz;
  logic [15:0] sc1, scz;
  logic [1:0]  sc3;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .RW(3), .NUM_SRC(2), .LOAD_STALL(1), .ZERO_REG(0), .CNT_W(16)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_wb(id_wb),
    .id_is_load(id_is_load), .flush(flush), .fwd_sel(fs1),
    .stall(st1), .ex_bubble(eb1), .stall_count(sc1)
  );

  hazard_forward_unit #(
    .RW(3), .NUM_SRC(2), .LOAD_STALL(3), .ZERO_REG(0), .CNT_W(2)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_wb(id_wb),
    .id_is_load(id_is_load), .flush(flush), .fwd_sel(fs3),
    .stall(st3), .ex_bubble(eb3), .stall_count(sc3)
  );

  hazard_forward_unit #(
    .RW(3), .NUM_SRC(2), .LOAD_STALL(1), .ZERO_REG(1), .CNT_W(16)
  ) uz (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_wb(id_wb),
    .id_is_load(id_is_load), .flush(flush), .fwd_sel(fsz),
    .stall(stz), .ex_bubble(ebz), .stall_count(scz)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] s1,
                     input logic [2:0] s0, input logic [1:0] used,
                     input logic [2:0] d, input logic wb,
                     input logic ld);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_dest     = d;
    id_wb       = wb;
    id_is_load  = ld;
    #1;
  endtask

  task automatic nop;
    put(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    do_reset();

    chk("rst_stall", 32'(st1), 0);
    chk("rst_fwd", 32'(fs1), 0);
    chk("rst_bubble", 32'(eb1), 1);
    chk("rst_count", 32'(sc1), 0);

    // ADD r1 then ADD r2,r1,r1
    put(1'b1, 3'd3, 3'd2, 2'b11, 3'd1, 1'b1, 1'b0);
    chk("nodep_bubble", 32'(eb1), 0);
    chk("nodep_fwd", 32'(fs1), 0);
    step();
    put(1'b1, 3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("ex_fwd", 32'(fs1), 4'b0101);
    chk("ex_stall", 32'(st1), 0);
    put(1'b1, 3'd1, 3'd1, 2'b00, 3'd2, 1'b1, 1'b0);
    chk("unused_src", 32'(fs1), 0);
    nop();
    step();
    put(1'b1, 3'd4, 3'd1, 2'b11, 3'd3, 1'b1, 1'b0);
    chk("mem_fwd", 32'(fs1), 4'b0010);
    nop();
    step();
    put(1'b1, 3'd4, 3'd1, 2'b11, 3'd3, 1'b1, 1'b0);
    chk("wb_fwd", 32'(fs1), 4'b0011);
    nop();
    step();
    put(1'b1, 3'd4, 3'd1, 2'b11, 3'd3, 1'b1, 1'b0);
    chk("gone_fwd", 32'(fs1), 0);

    // two writers of r1: youngest (EX) wins over MEM
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0);
    step();
    put(1'b1, 3'd6, 3'd7, 2'b11, 3'd1, 1'b1, 1'b0);
    step();
    put(1'b1, 3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("youngest", 32'(fs1), 4'b0101);

    // store to r1 never forwards
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b0, 1'b0);
    step();
    put(1'b1, 3'd1, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("store_nofwd", 32'(fs1), 0);

    // LW r1 then ADD r2,r1,r5
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b1);
    step();
    put(1'b1, 3'd5, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("lu1_stall", 32'(st1), 1);
    chk("lu1_bubble", 32'(eb1), 1);
    chk("lu1_fwd_ex", 32'(fs1), 4'b0001);
    chk("lu3_stall0", 32'(st3), 1);
    step();
    chk("lu1_release", 32'(st1), 0);
    chk("lu1_fwd_mem", 32'(fs1), 4'b0010);
    chk("lu1_issue", 32'(eb1), 0);
    chk("lu1_count", 32'(sc1), 1);
    chk("lu3_stall1", 32'(st3), 1);
    chk("lu3_fwd_mem", 32'(fs3), 4'b0010);
    step();
    chk("lu3_stall2", 32'(st3), 1);
    chk("lu3_fwd_wb", 32'(fs3), 4'b0011);
    step();
    chk("lu3_release", 32'(st3), 0);
    chk("lu3_fwd_rf", 32'(fs3), 0);
    chk("lu3_issue", 32'(eb3), 0);
    chk("lu3_count", 32'(sc3), 3);
    nop();
    step();

    // second load-use: 2-bit counter must hold at 3
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b1);
    step();
    put(1'b1, 3'd5, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("lu3_hold", 32'(st3), 1);
      step();
    end
    chk("lu3_end", 32'(st3), 0);
    chk("sat_count", 32'(sc3), 3);
    chk("lu1_count2", 32'(sc1), 2);

    // flush in the hazard cycle
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b1);
    step();
    put(1'b1, 3'd5, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl0_stall3", 32'(st3), 0);
    chk("fl0_bubble3", 32'(eb3), 1);
    chk("fl0_stall1", 32'(st1), 0);
    step();
    flush = 1'b0;
    #1;
    chk("fl0_after", 32'(st3), 0);
    chk("fl0_fwd", 32'(fs3), 4'b0010);
    chk("fl0_issue", 32'(eb3), 0);

    // flush in the second stall cycle
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b1);
    step();
    put(1'b1, 3'd5, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("fl1_first", 32'(st3), 1);
    step();
    flush = 1'b1;
    #1;
    chk("fl1_stall", 32'(st3), 0);
    chk("fl1_bubble", 32'(eb3), 1);
    step();
    flush = 1'b0;
    #1;
    chk("fl1_after", 32'(st3), 0);
    chk("fl1_issue", 32'(eb3), 0);
    chk("fl1_count", 32'(sc3), 1);

    // reset in the middle of a stall
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b1);
    step();
    put(1'b1, 3'd5, 3'd1, 2'b11, 3'd2, 1'b1, 1'b0);
    step();
    chk("mid_stall", 32'(st3), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(st3), 0);
    chk("mid_rst_count", 32'(sc3), 0);
    chk("mid_rst_fwd", 32'(fs3), 0);

    // r0 is hard-wired only in the ZERO_REG instance
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd0, 1'b1, 1'b0);
    step();
    put(1'b1, 3'd0, 3'd0, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("zr_fwd", 32'(fsz), 0);
    chk("nzr_fwd", 32'(fs1), 4'b0101);
    do_reset();
    put(1'b1, 3'd2, 3'd3, 2'b11, 3'd0, 1'b1, 1'b1);
    step();
    put(1'b1, 3'd4, 3'd0, 2'b11, 3'd2, 1'b1, 1'b0);
    chk("zr_nostall", 32'(stz), 0);
    chk("nzr_stall", 32'(st1), 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
